// File: rtl/cnn_pkg.sv
// cnn_pkg -- definitions shared by the CNN layer datapath blocks.
//
// Contents:
//   POOL_MAX / POOL_AVG   window reduction mode constants
//   pool_h_width()        width of a horizontal partial result (DW+1)
//   pool_v_width()        width of the full 2x2 window result (DW+2)
//   pool_reduce()         two-input reduction: signed max, or widened add
package cnn_pkg;

  localparam int POOL_MAX = 0;
  localparam int POOL_AVG = 1;

  // A pair sum needs one extra bit, a sum of two pairs needs two.
  function automatic int pool_h_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int pool_v_width(input int dw);
    return dw + 2;
  endfunction

  // Operands arrive sign-extended to 32 bits so a single function serves
  // every data width; callers truncate the result to the width they keep.
  function automatic logic signed [31:0] pool_reduce(
    input int                 mode,
    input logic signed [31:0] a,
    input logic signed [31:0] b
  );
    if (mode == POOL_AVG) begin
      return a + b;
    end
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// pool_line_buf -- one row of horizontal partial results for the pooling
// stage. Written on even rows, read on the following odd row.
//
// Ports:
//   clk    rising-edge clock
//   we     write enable for entry addr
//   addr   entry index (pixel column >> 1)
//   wdata  partial result to store
//   rdata  combinational read of entry addr
module pool_line_buf #(
  parameter int W     = 10,
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // NOTE: storage arrays carry no reset; every entry is written on an even
  // row before the odd row reads it, so reset would only cost a clear path.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/max_pool_stage.sv
// max_pool_stage -- streaming 2x2 / stride-2 pooling of a raster-order
// pixel stream, max or floor-average reduction.
//
// Parameters: DW data width, IMG_W x IMG_H frame geometry (each >= 2),
//             MODE 0 = max, 1 = average.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous, active-high
//   in_valid    pxl_in carries a pixel this cycle
//   in_sof      with in_valid: this pixel is (row 0, col 0)
//   pxl_in      signed input pixel
//   pool_out    registered pooled pixel
//   valid       one-cycle pulse, pool_out is new
//   frame_done  one-cycle pulse after the last pixel of a frame
//
// Build option: define MAX_POOL_STAGE_RELU_EN to clamp negative window
// results to zero at the output register.
module max_pool_stage
  import cnn_pkg::*;
#(
  parameter int DW    = 9,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int MODE  = POOL_MAX
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 in_sof,
  input  logic signed [DW-1:0] pxl_in,
  output logic signed [DW-1:0] pool_out,
  output logic                 valid,
  output logic                 frame_done
);

  localparam int HW    = pool_h_width(DW);
  localparam int VW    = pool_v_width(DW);
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int DEPTH = IMG_W / 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]        col, eff_col, col_nxt;
  logic [RW-1:0]        row, eff_row, row_nxt;
  logic signed [HW-1:0] h_reg, h_sum, lb_rdata;
  logic signed [VW-1:0] v_wide;
  logic signed [DW-1:0] v_res, v_out;
  logic [AW-1:0]        lb_addr;
  logic                 last_beat, lb_we, win_fire;

  // NOTE: every always_comb output gets a value before any branch, so no
  // path can leave one unassigned and infer a latch.
  always_comb begin
    // A start-of-frame beat is pixel (0,0) whatever the counters say; any
    // half-built window is simply never completed.
    eff_col   = in_sof ? '0 : col;
    eff_row   = in_sof ? '0 : row;
    last_beat = (eff_col == COL_LAST) && (eff_row == ROW_LAST);

    col_nxt = eff_col + CW'(1);
    row_nxt = eff_row;
    if (last_beat) begin
      col_nxt = '0;
      row_nxt = '0;
    end else if (eff_col == COL_LAST) begin
      col_nxt = '0;
      row_nxt = eff_row + RW'(1);
    end

    // Odd columns pair with the even column held in h_reg. A trailing odd
    // column of an odd-width frame is even-indexed and never pairs up.
    h_sum    = HW'(pool_reduce(MODE, 32'(h_reg), 32'(pxl_in)));
    lb_addr  = AW'(eff_col >> 1);
    lb_we    = in_valid && !eff_row[0] && eff_col[0];
    win_fire = in_valid && eff_row[0] && eff_col[0];

    v_wide = VW'(pool_reduce(MODE, 32'(lb_rdata), 32'(h_sum)));
    if (MODE == POOL_AVG) begin
      // Arithmetic shift floors toward -inf; the quotient always fits DW.
      v_res = DW'(v_wide >>> 2);
    end else begin
      v_res = DW'(v_wide);
    end

`ifdef MAX_POOL_STAGE_RELU_EN
    v_out = (v_res < 0) ? '0 : v_res;
`else
    v_out = v_res;
`endif
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col        <= '0;
      row        <= '0;
      h_reg      <= '0;
      pool_out   <= '0;
      valid      <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      valid      <= win_fire;
      frame_done <= in_valid && last_beat;
      if (in_valid) begin
        col <= col_nxt;
        row <= row_nxt;
        if (!eff_col[0]) begin
          h_reg <= HW'(pxl_in);
        end
      end
      if (win_fire) begin
        pool_out <= v_out;
      end
    end
  end

  pool_line_buf #(
    .W     (HW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_line_buf (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (h_sum),
    .rdata (lb_rdata)
  );

endmodule

// File: tb/tb_max_pool_stage.sv
// tb_max_pool_stage -- bench for max_pool_stage. Three frame geometries
// (4x4, 28x28, 5x5), each driving a max and an average instance from one
// shared input stream. Instance k belongs to group k/2; k even is max.
module tb_max_pool_stage;

  localparam int DW = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 reset;
  logic                 iv  [3];
  logic                 sof [3];
  logic signed [DW-1:0] px  [3];
  logic signed [DW-1:0] pout[6];
  logic                 vld [6];
  logic                 fdn [6];

  max_pool_stage #(.DW(DW), .IMG_W(4), .IMG_H(4), .MODE(0)) u_max4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_sof(sof[0]), .pxl_in(px[0]),
    .pool_out(pout[0]), .valid(vld[0]), .frame_done(fdn[0]));
  max_pool_stage #(.DW(DW), .IMG_W(4), .IMG_H(4), .MODE(1)) u_avg4 (
    .clk(clk), .reset(reset), .in_valid(iv[0]), .in_sof(sof[0]), .pxl_in(px[0]),
    .pool_out(pout[1]), .valid(vld[1]), .frame_done(fdn[1]));
  max_pool_stage #(.DW(DW), .IMG_W(28), .IMG_H(28), .MODE(0)) u_max28 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_sof(sof[1]), .pxl_in(px[1]),
    .pool_out(pout[2]), .valid(vld[2]), .frame_done(fdn[2]));
  max_pool_stage #(.DW(DW), .IMG_W(28), .IMG_H(28), .MODE(1)) u_avg28 (
    .clk(clk), .reset(reset), .in_valid(iv[1]), .in_sof(sof[1]), .pxl_in(px[1]),
    .pool_out(pout[3]), .valid(vld[3]), .frame_done(fdn[3]));
  max_pool_stage #(.DW(DW), .IMG_W(5), .IMG_H(5), .MODE(0)) u_max5 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_sof(sof[2]), .pxl_in(px[2]),
    .pool_out(pout[4]), .valid(vld[4]), .frame_done(fdn[4]));
  max_pool_stage #(.DW(DW), .IMG_W(5), .IMG_H(5), .MODE(1)) u_avg5 (
    .clk(clk), .reset(reset), .in_valid(iv[2]), .in_sof(sof[2]), .pxl_in(px[2]),
    .pool_out(pout[5]), .valid(vld[5]), .frame_done(fdn[5]));

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Observed results, appended by the monitor only.
  int obs_q [6][$];
  int vstamp[6][$];
  int fd_cnt [6];
  int fd_lone[6];

  // Reference data, written by the test sequence only.
  int frm  [3][784];
  int exp_q[6][$];
  int bcyc [$];
  int ob   [6];
  int fb   [6];
  int fl   [6];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    for (int i = 0; i < 6; i++) begin
      if (vld[i] === 1'b1) begin
        obs_q[i].push_back(int'(pout[i]));
        vstamp[i].push_back(cyc);
      end
      if (fdn[i] === 1'b1) begin
        fd_cnt[i]++;
        if (vld[i] !== 1'b1) fd_lone[i]++;
      end
    end
  end

  function automatic int gw(input int g);
    return (g == 0) ? 4 : (g == 1) ? 28 : 5;
  endfunction

  function automatic int gh(input int g);
    return (g == 0) ? 4 : (g == 1) ? 28 : 5;
  endfunction

  // One 2x2 window: largest of four, or floor(sum / 4) by integer division.
  function automatic int win_val(input int mode, input int a, input int b,
                                 input int c, input int d);
    int r;
    int s;
    if (mode == 0) begin
      r = a;
      if (b > r) r = b;
      if (c > r) r = c;
      if (d > r) r = d;
    end else begin
      s = a + b + c + d;
      r = (s >= 0) ? s / 4 : -((-s + 3) / 4);
    end
`ifdef MAX_POOL_STAGE_RELU_EN
    if (r < 0) r = 0;
`endif
    return r;
  endfunction

  // Expected outputs of a frame of group g of which only the first n
  // pixels were delivered: a window counts once its bottom-right pixel
  // has arrived.
  task automatic model_frame(input int g, input int n);
    int w;
    int tl;
    int br;
    w = gw(g);
    for (int wr = 0; wr < gh(g) / 2; wr++) begin
      for (int wc = 0; wc < w / 2; wc++) begin
        tl = 2 * wr * w + 2 * wc;
        br = tl + w + 1;
        if (br < n) begin
          for (int m = 0; m < 2; m++) begin
            exp_q[2 * g + m].push_back(win_val(m, frm[g][tl], frm[g][tl + 1],
                                               frm[g][tl + w], frm[g][br]));
          end
        end
      end
    end
  endtask

  task automatic fill_random(input int g);
    for (int k = 0; k < 784; k++) frm[g][k] = int'($urandom_range(511)) - 256;
  endtask

  task automatic drive_frame(input int g, input int n, input bit sof_first,
                             input int gap_pct);
    int gaps;
    bcyc.delete();
    for (int k = 0; k < n; k++) begin
      gaps = 0;
      while (gap_pct > 0 && gaps < 8 && $urandom_range(99) < gap_pct) begin
        iv[g]  = 1'b0;
        sof[g] = 1'b0;
        px[g]  = DW'($urandom);
        @(posedge clk); #1;
        gaps++;
      end
      iv[g]  = 1'b1;
      sof[g] = sof_first && (k == 0);
      px[g]  = DW'(frm[g][k]);
      bcyc.push_back(cyc);
      @(posedge clk); #1;
    end
    iv[g]  = 1'b0;
    sof[g] = 1'b0;
  endtask

  task automatic mark;
    for (int i = 0; i < 6; i++) begin
      ob[i] = obs_q[i].size();
      fb[i] = fd_cnt[i];
      fl[i] = fd_lone[i];
      exp_q[i].delete();
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) begin
      n_checks += 3;
      if (pout[i] !== '0) begin
        n_fail++; $display("FAIL reset_pool_out[%0d]: got %0d want 0", i, pout[i]);
      end
      if (vld[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_valid[%0d]: got %b want 0", i, vld[i]);
      end
      if (fdn[i] !== 1'b0) begin
        n_fail++; $display("FAIL reset_frame_done[%0d]: got %b want 0", i, fdn[i]);
      end
    end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ramp;
    int j;
    mark();
    for (int k = 0; k < 16; k++) frm[0][k] = k;
    drive_frame(0, 16, 1'b1, 0);
    model_frame(0, 16);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks += 3;
      if (obs_q[i].size() - ob[i] != exp_q[i].size()) begin
        n_fail++; $display("FAIL ramp_count[%0d]: got %0d want %0d", i,
                           obs_q[i].size() - ob[i], exp_q[i].size());
      end
      if (fd_cnt[i] - fb[i] != 1) begin
        n_fail++; $display("FAIL ramp_frame_done[%0d]: got %0d want 1", i, fd_cnt[i] - fb[i]);
      end
      if (fd_lone[i] != fl[i]) begin
        n_fail++; $display("FAIL ramp_frame_done_align[%0d]: frame_done without valid", i);
      end
      for (int k = 0; k < exp_q[i].size(); k++) begin
        if (ob[i] + k < obs_q[i].size()) begin
          n_checks++;
          if (obs_q[i][ob[i] + k] != exp_q[i][k]) begin
            n_fail++; $display("FAIL ramp_value[%0d][%0d]: got %0d want %0d", i, k,
                               obs_q[i][ob[i] + k], exp_q[i][k]);
          end
        end
      end
    end
    // Output latency: one cycle after beats 5, 7, 13 and 15.
    j = 0;
    for (int br = 5; br < 16; br += (br == 7) ? 6 : 2) begin
      if (ob[0] + j < vstamp[0].size()) begin
        n_checks++;
        if (vstamp[0][ob[0] + j] != bcyc[br] + 1) begin
          n_fail++; $display("FAIL ramp_latency[%0d]: got cycle %0d want %0d", j,
                             vstamp[0][ob[0] + j], bcyc[br] + 1);
        end
      end
      j++;
    end
  endtask

  task automatic test_negative;
    mark();
    for (int k = 0; k < 16; k++) frm[0][k] = int'($urandom_range(511)) - 256;
    frm[0][0] = -1;
    frm[0][1] = -2;
    frm[0][4] = -3;
    frm[0][5] = -4;
    drive_frame(0, 16, 1'b1, 0);
    model_frame(0, 16);
    // Second frame follows immediately and relies on counter wrap.
    for (int k = 0; k < 16; k++) frm[0][k] = -5;
    drive_frame(0, 16, 1'b0, 0);
    model_frame(0, 16);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks += 2;
      if (obs_q[i].size() - ob[i] != exp_q[i].size()) begin
        n_fail++; $display("FAIL neg_count[%0d]: got %0d want %0d", i,
                           obs_q[i].size() - ob[i], exp_q[i].size());
      end
      if (fd_cnt[i] - fb[i] != 2) begin
        n_fail++; $display("FAIL neg_frame_done[%0d]: got %0d want 2", i, fd_cnt[i] - fb[i]);
      end
      for (int k = 0; k < exp_q[i].size(); k++) begin
        if (ob[i] + k < obs_q[i].size()) begin
          n_checks++;
          if (obs_q[i][ob[i] + k] != exp_q[i][k]) begin
            n_fail++; $display("FAIL neg_value[%0d][%0d]: got %0d want %0d", i, k,
                               obs_q[i][ob[i] + k], exp_q[i][k]);
          end
        end
      end
    end
  endtask

  task automatic test_sof;
    mark();
    // Frame cut short by a new start of frame at (1,2).
    fill_random(0);
    drive_frame(0, 6, 1'b1, 0);
    model_frame(0, 6);
    fill_random(0);
    drive_frame(0, 16, 1'b1, 0);
    model_frame(0, 16);
    // Start of frame landing on what would be the last pixel.
    fill_random(0);
    drive_frame(0, 15, 1'b0, 0);
    model_frame(0, 15);
    fill_random(0);
    drive_frame(0, 16, 1'b1, 0);
    model_frame(0, 16);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks += 2;
      if (obs_q[i].size() - ob[i] != exp_q[i].size()) begin
        n_fail++; $display("FAIL sof_count[%0d]: got %0d want %0d", i,
                           obs_q[i].size() - ob[i], exp_q[i].size());
      end
      if (fd_cnt[i] - fb[i] != 2) begin
        n_fail++; $display("FAIL sof_frame_done[%0d]: got %0d want 2", i, fd_cnt[i] - fb[i]);
      end
      for (int k = 0; k < exp_q[i].size(); k++) begin
        if (ob[i] + k < obs_q[i].size()) begin
          n_checks++;
          if (obs_q[i][ob[i] + k] != exp_q[i][k]) begin
            n_fail++; $display("FAIL sof_value[%0d][%0d]: got %0d want %0d", i, k,
                               obs_q[i][ob[i] + k], exp_q[i][k]);
          end
        end
      end
    end
  endtask

  task automatic test_gaps_28;
    mark();
    fill_random(1);
    drive_frame(1, 784, 1'b1, 50);
    model_frame(1, 784);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 2; i < 4; i++) begin
      n_checks += 3;
      if (obs_q[i].size() - ob[i] != 196) begin
        n_fail++; $display("FAIL gaps_count[%0d]: got %0d want 196", i, obs_q[i].size() - ob[i]);
      end
      if (fd_cnt[i] - fb[i] != 1) begin
        n_fail++; $display("FAIL gaps_frame_done[%0d]: got %0d want 1", i, fd_cnt[i] - fb[i]);
      end
      if (fd_lone[i] != fl[i]) begin
        n_fail++; $display("FAIL gaps_frame_done_align[%0d]: frame_done without valid", i);
      end
      for (int k = 0; k < exp_q[i].size(); k++) begin
        if (ob[i] + k < obs_q[i].size()) begin
          n_checks++;
          if (obs_q[i][ob[i] + k] != exp_q[i][k]) begin
            n_fail++; $display("FAIL gaps_value[%0d][%0d]: got %0d want %0d", i, k,
                               obs_q[i][ob[i] + k], exp_q[i][k]);
          end
        end
      end
    end
  endtask

  task automatic test_odd_geom;
    mark();
    fill_random(2);
    drive_frame(2, 25, 1'b1, 0);
    model_frame(2, 25);
    fill_random(2);
    drive_frame(2, 25, 1'b0, 30);
    model_frame(2, 25);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 4; i < 6; i++) begin
      n_checks += 2;
      if (obs_q[i].size() - ob[i] != 8) begin
        n_fail++; $display("FAIL odd_count[%0d]: got %0d want 8", i, obs_q[i].size() - ob[i]);
      end
      if (fd_cnt[i] - fb[i] != 2) begin
        n_fail++; $display("FAIL odd_frame_done[%0d]: got %0d want 2", i, fd_cnt[i] - fb[i]);
      end
      for (int k = 0; k < exp_q[i].size(); k++) begin
        if (ob[i] + k < obs_q[i].size()) begin
          n_checks++;
          if (obs_q[i][ob[i] + k] != exp_q[i][k]) begin
            n_fail++; $display("FAIL odd_value[%0d][%0d]: got %0d want %0d", i, k,
                               obs_q[i][ob[i] + k], exp_q[i][k]);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 16; k++) frm[0][k] = k;
    drive_frame(0, 6, 1'b1, 0);
    // Beat (1,1) has just been accepted: its window is on the outputs.
    n_checks += 2;
    if (vld[0] !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre_valid: got %b want 1", vld[0]);
    end
    if (pout[0] !== 9'sd5) begin
      n_fail++; $display("FAIL rstmid_pre_pool_out: got %0d want 5", pout[0]);
    end
    #1 reset = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks += 2;
      if (pout[i] !== '0) begin
        n_fail++; $display("FAIL rstmid_pool_out[%0d]: got %0d want 0", i, pout[i]);
      end
      if (vld[i] !== 1'b0) begin
        n_fail++; $display("FAIL rstmid_valid[%0d]: got %b want 0", i, vld[i]);
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    mark();
    // No start-of-frame marker: reset alone must restart at (0,0).
    drive_frame(0, 16, 1'b0, 0);
    model_frame(0, 16);
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      n_checks += 2;
      if (obs_q[i].size() - ob[i] != 4) begin
        n_fail++; $display("FAIL rstmid_count[%0d]: got %0d want 4", i, obs_q[i].size() - ob[i]);
      end
      if (fd_cnt[i] - fb[i] != 1) begin
        n_fail++; $display("FAIL rstmid_frame_done[%0d]: got %0d want 1", i, fd_cnt[i] - fb[i]);
      end
      for (int k = 0; k < exp_q[i].size(); k++) begin
        if (ob[i] + k < obs_q[i].size()) begin
          n_checks++;
          if (obs_q[i][ob[i] + k] != exp_q[i][k]) begin
            n_fail++; $display("FAIL rstmid_value[%0d][%0d]: got %0d want %0d", i, k,
                               obs_q[i][ob[i] + k], exp_q[i][k]);
          end
        end
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    for (int g = 0; g < 3; g++) begin
      iv[g]  = 1'b0;
      sof[g] = 1'b0;
      px[g]  = '0;
    end
    test_reset();
    test_ramp();
    test_negative();
    test_sof();
    test_gaps_28();
    test_odd_geom();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
